// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory. Every access takes
// three cycles: capture in IDLE, drive the memory in ACCESS, return data in RESP.
module mem_port_arbiter #(
  parameter int BITS_DATA  = 32,
  parameter int BITS_ADDR  = 16,
  parameter int PRIO_FIXED = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [BITS_ADDR-1:0] addr0,
  input  logic [BITS_DATA-1:0] wdata0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [BITS_DATA-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [BITS_ADDR-1:0] addr1,
  input  logic [BITS_DATA-1:0] wdata1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [BITS_DATA-1:0] rdata1,
  output logic [BITS_ADDR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic [BITS_DATA-1:0] mem_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t state_r;
  logic   owner_r;
  logic   last_owner_r;
  logic   we_r;
  logic   winner_s;

  // Tie-break: alternate against the last owner, or port 0 first when fixed.
  always_comb begin
    winner_s = 1'b0;
    if (req0 && req1) begin
      if (PRIO_FIXED != 0) begin
        winner_s = 1'b0;
      end else begin
        winner_s = ~last_owner_r;
      end
    end else if (req1) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Access sequencer; all handshake and memory-side outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      we_r         <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata0       <= {BITS_DATA{1'b0}};
      rdata1       <= {BITS_DATA{1'b0}};
      mem_addr     <= {BITS_ADDR{1'b0}};
      mem_wdata    <= {BITS_DATA{1'b0}};
      mem_write    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          if (req0 || req1) begin
            state_r      <= ACCESS;
            busy         <= 1'b1;
            owner_r      <= winner_s;
            last_owner_r <= winner_s;
            gnt0         <= ~winner_s;
            gnt1         <= winner_s;
            if (winner_s) begin
              mem_addr  <= addr1;
              mem_wdata <= wdata1;
              mem_write <= we1;
              we_r      <= we1;
            end else begin
              mem_addr  <= addr0;
              mem_wdata <= wdata0;
              mem_write <= we0;
              we_r      <= we0;
            end
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        ACCESS: begin
          // The write commits at this edge; mem_addr stays put for the read return.
          state_r   <= RESP;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          mem_write <= 1'b0;
        end
        RESP: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          if (owner_r) begin
            rvalid1 <= 1'b1;
            if (!we_r) begin
              rdata1 <= mem_rdata;
            end
          end else begin
            rvalid0 <= 1'b1;
            if (!we_r) begin
              rdata0 <= mem_rdata;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          rvalid0   <= 1'b0;
          rvalid1   <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share the same
// requester stimulus; each has its own behavioural memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;

  logic        a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mem_write, a_busy;
  logic [31:0] a_rdata0, a_rdata1, a_mem_wdata, a_mem_rdata;
  logic [15:0] a_mem_addr;
  logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_mem_write, f_busy;
  logic [31:0] f_rdata0, f_rdata1, f_mem_wdata, f_mem_rdata;
  logic [15:0] f_mem_addr;

  logic [31:0] mem_a [0:65535];
  logic [31:0] mem_f [0:65535];
  logic [31:0] ref_mem [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [31:0] bd_data;

  logic [5:0]  a_ctl, f_ctl;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Control bits packed as {gnt0, gnt1, rvalid0, rvalid1, busy, mem_write}.
  assign a_ctl = {a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_busy, a_mem_write};
  assign f_ctl = {f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_busy, f_mem_write};
  assign a_mem_rdata = mem_a[a_mem_addr];
  assign f_mem_rdata = mem_f[f_mem_addr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_mem_write) mem_a[a_mem_addr] <= a_mem_wdata;
    else if (bd_we) mem_a[bd_addr] <= bd_data;
    if (f_mem_write) mem_f[f_mem_addr] <= f_mem_wdata;
    else if (bd_we) mem_f[bd_addr] <= bd_data;
  end

  mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .PRIO_FIXED(0)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(a_gnt0), .rvalid0(a_rvalid0), .rdata0(a_rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(a_gnt1), .rvalid1(a_rvalid1), .rdata1(a_rdata1),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_write(a_mem_write),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .PRIO_FIXED(1)) dut_fx (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_write(f_mem_write),
    .mem_rdata(f_mem_rdata), .busy(f_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp += 4;
    if (a_ctl !== 6'b0) begin n_bad++; $display("FAIL reset_ctl_rr: got %b expected 000000", a_ctl); end
    if (f_ctl !== 6'b0) begin n_bad++; $display("FAIL reset_ctl_fx: got %b expected 000000", f_ctl); end
    if ({a_mem_addr, a_mem_wdata, a_rdata0, a_rdata1} !== 112'd0) begin
      n_bad++; $display("FAIL reset_data_rr: got %h %h %h %h expected all zero", a_mem_addr, a_mem_wdata, a_rdata0, a_rdata1);
    end
    if ({f_mem_addr, f_mem_wdata, f_rdata0, f_rdata1} !== 112'd0) begin
      n_bad++; $display("FAIL reset_data_fx: got %h %h %h %h expected all zero", f_mem_addr, f_mem_wdata, f_rdata0, f_rdata1);
    end
  endtask

  task automatic test_read();
    load(16'h0010, 32'hDEADBEEF);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    tick();
    n_cmp += 3;
    if (a_ctl !== 6'b100010) begin n_bad++; $display("FAIL read_gnt: got %b expected 100010", a_ctl); end
    if (f_ctl !== 6'b100010) begin n_bad++; $display("FAIL read_gnt_fx: got %b expected 100010", f_ctl); end
    if (a_mem_addr !== 16'h0010) begin n_bad++; $display("FAIL read_addr: got %h expected 0010", a_mem_addr); end
    req0 = 1'b0;
    tick();
    n_cmp += 2;
    if (a_ctl !== 6'b000010) begin n_bad++; $display("FAIL read_resp: got %b expected 000010", a_ctl); end
    if (a_mem_addr !== 16'h0010) begin n_bad++; $display("FAIL read_addr_hold: got %h expected 0010", a_mem_addr); end
    tick();
    n_cmp += 3;
    if (a_ctl !== 6'b001000) begin n_bad++; $display("FAIL read_rvalid: got %b expected 001000", a_ctl); end
    if (a_rdata0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data: got %h expected deadbeef", a_rdata0); end
    if (f_rdata0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data_fx: got %h expected deadbeef", f_rdata0); end
    tick();
    n_cmp++;
    if (a_ctl !== 6'b000000) begin n_bad++; $display("FAIL read_idle: got %b expected 000000", a_ctl); end
  endtask

  task automatic test_write();
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h00FF; wdata1 = 32'h12345678;
    tick();
    n_cmp += 2;
    if (a_ctl !== 6'b010011) begin n_bad++; $display("FAIL write_gnt: got %b expected 010011", a_ctl); end
    if (a_mem_wdata !== 32'h12345678) begin n_bad++; $display("FAIL write_wdata: got %h expected 12345678", a_mem_wdata); end
    req1 = 1'b0;
    tick();
    n_cmp++;
    if (a_ctl !== 6'b000010) begin n_bad++; $display("FAIL write_we_drop: got %b expected 000010", a_ctl); end
    tick();
    n_cmp += 3;
    if (a_ctl !== 6'b000100) begin n_bad++; $display("FAIL write_rvalid: got %b expected 000100", a_ctl); end
    if (a_rdata1 !== 32'h0) begin n_bad++; $display("FAIL write_rdata_kept: got %h expected 00000000", a_rdata1); end
    if (mem_a[16'h00FF] !== 32'h12345678) begin n_bad++; $display("FAIL write_mem: got %h expected 12345678", mem_a[16'h00FF]); end
    req1 = 1'b1; we1 = 1'b0;
    tick();
    n_cmp++;
    if (a_ctl !== 6'b010010) begin n_bad++; $display("FAIL rdback_gnt: got %b expected 010010", a_ctl); end
    req1 = 1'b0;
    tick(); tick();
    n_cmp += 2;
    if (a_ctl !== 6'b000100) begin n_bad++; $display("FAIL rdback_rvalid: got %b expected 000100", a_ctl); end
    if (a_rdata1 !== 32'h12345678) begin n_bad++; $display("FAIL rdback_data: got %h expected 12345678", a_rdata1); end
    tick();
  endtask

  task automatic test_arbitration();
    logic [5:0] exp_a, exp_f;
    reset = 1'b1; tick(); reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h00FF;
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 1) ? 6'b010010 : 6'b100010;
      exp_f = 6'b100010;
      tick();
      n_cmp += 2;
      if (a_ctl !== exp_a) begin n_bad++; $display("FAIL rr_gnt%0d: got %b expected %b", k, a_ctl, exp_a); end
      if (f_ctl !== exp_f) begin n_bad++; $display("FAIL fx_gnt%0d: got %b expected %b", k, f_ctl, exp_f); end
      tick();
      n_cmp += 2;
      if (a_ctl !== 6'b000010) begin n_bad++; $display("FAIL rr_gap%0d: got %b expected 000010", k, a_ctl); end
      if (f_ctl !== 6'b000010) begin n_bad++; $display("FAIL fx_gap%0d: got %b expected 000010", k, f_ctl); end
      exp_a = (k % 2 == 1) ? 6'b000100 : 6'b001000;
      exp_f = 6'b001000;
      tick();
      n_cmp += 2;
      if (a_ctl !== exp_a) begin n_bad++; $display("FAIL rr_rvalid%0d: got %b expected %b", k, a_ctl, exp_a); end
      if (f_ctl !== exp_f) begin n_bad++; $display("FAIL fx_rvalid%0d: got %b expected %b", k, f_ctl, exp_f); end
    end
    n_cmp += 2;
    if (a_rdata1 !== 32'h12345678) begin n_bad++; $display("FAIL rr_rdata1: got %h expected 12345678", a_rdata1); end
    if (f_rdata0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fx_rdata0: got %h expected deadbeef", f_rdata0); end
    req0 = 1'b0;
    tick();
    n_cmp++;
    if (f_ctl !== 6'b010010) begin n_bad++; $display("FAIL fx_port1_after_drop: got %b expected 010010", f_ctl); end
    req1 = 1'b0;
    tick(); tick();
    n_cmp += 2;
    if (f_ctl !== 6'b000100) begin n_bad++; $display("FAIL fx_port1_rvalid: got %b expected 000100", f_ctl); end
    if (f_rdata1 !== 32'h12345678) begin n_bad++; $display("FAIL fx_port1_data: got %h expected 12345678", f_rdata1); end
    tick();
  endtask

  task automatic test_reset_in_access();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 32'hAAAA5555;
    tick();
    n_cmp++;
    if (a_ctl !== 6'b100011) begin n_bad++; $display("FAIL rsta_gnt: got %b expected 100011", a_ctl); end
    req0 = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp += 4;
    if (mem_a[16'h0020] !== 32'hAAAA5555) begin n_bad++; $display("FAIL rsta_commit: got %h expected aaaa5555", mem_a[16'h0020]); end
    if (mem_f[16'h0020] !== 32'hAAAA5555) begin n_bad++; $display("FAIL rsta_commit_fx: got %h expected aaaa5555", mem_f[16'h0020]); end
    if (a_ctl !== 6'b0) begin n_bad++; $display("FAIL rsta_ctl: got %b expected 000000", a_ctl); end
    if ({a_mem_addr, a_mem_wdata, a_rdata0, a_rdata1} !== 112'd0) begin
      n_bad++; $display("FAIL rsta_data: got %h %h %h %h expected all zero", a_mem_addr, a_mem_wdata, a_rdata0, a_rdata1);
    end
    tick();
    n_cmp++;
    if (a_ctl !== 6'b0) begin n_bad++; $display("FAIL rsta_no_rvalid: got %b expected 000000", a_ctl); end
    req0 = 1'b1; we0 = 1'b0;
    tick();
    n_cmp++;
    if (a_ctl !== 6'b100010) begin n_bad++; $display("FAIL rsta_next_gnt: got %b expected 100010", a_ctl); end
    req0 = 1'b0;
    tick(); tick();
    n_cmp += 2;
    if (a_ctl !== 6'b001000) begin n_bad++; $display("FAIL rsta_next_rvalid: got %b expected 001000", a_ctl); end
    if (a_rdata0 !== 32'hAAAA5555) begin n_bad++; $display("FAIL rsta_next_data: got %h expected aaaa5555", a_rdata0); end
    tick();
  endtask

  task automatic test_reset_in_resp();
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h00FF;
    tick();
    n_cmp++;
    if (a_ctl !== 6'b010010) begin n_bad++; $display("FAIL rstr_gnt: got %b expected 010010", a_ctl); end
    req1 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp += 2;
    if (a_ctl !== 6'b0) begin n_bad++; $display("FAIL rstr_ctl: got %b expected 000000", a_ctl); end
    if (a_rdata1 !== 32'h0) begin n_bad++; $display("FAIL rstr_rdata: got %h expected 00000000", a_rdata1); end
    tick();
    n_cmp += 2;
    if (a_ctl !== 6'b0) begin n_bad++; $display("FAIL rstr_after: got %b expected 000000", a_ctl); end
    if (a_rdata1 !== 32'h0) begin n_bad++; $display("FAIL rstr_rdata_after: got %h expected 00000000", a_rdata1); end
  endtask

  // Randomised traffic on the round-robin arbiter against a transaction model.
  task automatic test_random();
    int          cyc = 0;
    int          free_at = 0;
    int          gnt_at = -10;
    logic        last_m = 1'b1;
    logic        p;
    logic        pend_p = 1'b0;
    logic        pend_we = 1'b0;
    logic [15:0] pend_a = 16'h0;
    logic [31:0] pend_v = 32'h0;
    logic [31:0] exp_rd0 = 32'h0;
    logic [31:0] exp_rd1 = 32'h0;
    logic [5:0]  exp_ctl;
    logic        exp_busy;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) load(16'h0040 + 16'(i), $urandom);
    tick();
    reset = 1'b0;
    for (int it = 0; it < 400; it++) begin
      if (cyc >= free_at && (req0 || req1)) begin
        p = (req0 && req1) ? ~last_m : req1;
        last_m = p; gnt_at = cyc; free_at = cyc + 3; pend_p = p;
        pend_we = p ? we1 : we0;
        pend_a = p ? addr1 : addr0;
        if (pend_we) ref_mem[pend_a] = p ? wdata1 : wdata0;
        else pend_v = ref_mem[pend_a];
      end
      tick();
      if (cyc == gnt_at + 2 && !pend_we) begin
        if (pend_p) exp_rd1 = pend_v;
        else exp_rd0 = pend_v;
      end
      exp_busy = (cyc == gnt_at) || (cyc == gnt_at + 1);
      exp_ctl = {(cyc == gnt_at) && !pend_p, (cyc == gnt_at) && pend_p,
                 (cyc == gnt_at + 2) && !pend_p, (cyc == gnt_at + 2) && pend_p,
                 exp_busy, (cyc == gnt_at) && pend_we};
      n_cmp += 3;
      if (a_ctl !== exp_ctl) begin n_bad++; $display("FAIL rnd_ctl@%0d: got %b expected %b", cyc, a_ctl, exp_ctl); end
      if (a_rdata0 !== exp_rd0) begin n_bad++; $display("FAIL rnd_rdata0@%0d: got %h expected %h", cyc, a_rdata0, exp_rd0); end
      if (a_rdata1 !== exp_rd1) begin n_bad++; $display("FAIL rnd_rdata1@%0d: got %h expected %h", cyc, a_rdata1, exp_rd1); end
      if (exp_busy) begin
        n_cmp++;
        if (a_mem_addr !== pend_a) begin n_bad++; $display("FAIL rnd_addr@%0d: got %h expected %h", cyc, a_mem_addr, pend_a); end
      end
      if (req0) begin
        if (cyc == gnt_at && !pend_p) begin
          req0 = ($urandom_range(0, 1) == 1);
          we0 = $urandom_range(0, 1) == 1; addr0 = 16'h0040 + 16'($urandom_range(0, 63)); wdata0 = $urandom;
        end
      end else if ($urandom_range(0, 9) < 4) begin
        req0 = 1'b1; we0 = $urandom_range(0, 1) == 1; addr0 = 16'h0040 + 16'($urandom_range(0, 63)); wdata0 = $urandom;
      end
      if (req1) begin
        if (cyc == gnt_at && pend_p) begin
          req1 = ($urandom_range(0, 1) == 1);
          we1 = $urandom_range(0, 1) == 1; addr1 = 16'h0040 + 16'($urandom_range(0, 63)); wdata1 = $urandom;
        end
      end else if ($urandom_range(0, 9) < 4) begin
        req1 = 1'b1; we1 = $urandom_range(0, 1) == 1; addr1 = 16'h0040 + 16'($urandom_range(0, 63)); wdata1 = $urandom;
      end
      cyc++;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 32'h0;
    bd_we = 1'b0; bd_addr = 16'h0; bd_data = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_reset_in_access();
    test_reset_in_resp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 32-bit-data / 16-bit-address data memory between two requesters.
- Port 0 is CPU instruction fetch; port 1 is CPU load/store data access.
- Serialises accesses through a 3-state sequencer and arbitrates simultaneous requests round-robin, or fixed-priority by parameter.
- Sits between the CPU stage machine and the memory instance and is the only driver of memory address, write data and write enable.

Parameters:
- BITS_DATA, 32, data word width.
- BITS_ADDR, 16, address width.
- PRIO_FIXED, 0, 0 = round-robin on ties; 1 = port 0 always wins ties.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req0  in  1  port 0 access request, level.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  BITS_ADDR  port 0 word address.
- wdata0  in  BITS_DATA  port 0 write data.
- gnt0  out  1  port 0 request accepted, 1-cycle pulse.
- rvalid0  out  1  port 0 access complete, 1-cycle pulse.
- rdata0  out  BITS_DATA  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_addr  out  BITS_ADDR  memory address.
- mem_wdata  out  BITS_DATA  memory write data.
- mem_write  out  1  memory write enable.
- mem_rdata  in  BITS_DATA  memory read data, asynchronous function of mem_addr.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - On the reset edge: state=IDLE; last_owner=1, so port 0 wins the first tie.
  - Outputs after reset: gnt*, rvalid*, mem_write, busy = 0; mem_addr, mem_wdata, rdata0, rdata1 = 0.
- States and transitions:
  - IDLE: at an edge with req0|req1, latch owner, addr, we and wdata of the winner; go to ACCESS. With no request, stay in IDLE.
  - ACCESS: at the next edge, unconditionally go to RESP.
  - RESP: at the next edge, unconditionally go to IDLE.
- Arbitration (IDLE only):
  - Single requester wins.
  - Both requesting with PRIO_FIXED=0: winner = ~last_owner.
  - Both requesting with PRIO_FIXED=1: winner = 0.
  - last_owner updated at every capture.
  - Requests are not sampled in ACCESS or RESP.
- Timing, with capture at edge E0:
  - Cycle E0–E1 (ACCESS): gnt[owner]=1; mem_addr=latched addr; mem_wdata=latched wdata; mem_write=latched we. All are registered outputs.
  - Edge E1: a write commits in memory. Then gnt=0 and mem_write=0; mem_addr is held.
  - Edge E2: rdata[owner] <= mem_rdata for reads only; writes leave rdata unchanged. rvalid[owner]=1 during cycle E2–E3, for reads and writes.
  - Earliest next capture is at E3. Throughput is 1 access per 3 cycles; read latency is req-sample to rvalid = 2 edges.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Drop req at the edge ending the gnt cycle unless issuing a new access.
  - A req still high in IDLE after rvalid is treated as a new access.
- rdata per port holds its last value until the next read completion on that port.
- Starvation: with PRIO_FIXED=0 and both ports requesting continuously, grants alternate 0,1,0,1…
- busy = (state != IDLE).
- Reset mid-operation:
  - Reset at the edge ending ACCESS: the write on the memory side still commits at that edge, since mem_write was high. No rvalid is issued and the arbiter returns to IDLE.
  - Reset in RESP: the pending rvalid and rdata update are dropped.
- Same-port back-to-back: a new access on a port is accepted only after that port's rvalid cycle. There is no overlap, so there is no hazard.

Test Plan:
- Reset, then req0=1, we0=0, addr0=0x0010, memory[0x0010]=0xDEADBEEF → gnt0 in cycle 1; mem_addr=0x0010; rvalid0 in cycle 3 with rdata0=0xDEADBEEF; busy high for 2 cycles.
- req1=1, we1=1, addr1=0x00FF, wdata1=0x12345678, then a port 1 read of 0x00FF → mem_write high for exactly 1 cycle; rvalid1 for the write; the read returns 0x12345678; rdata1 unchanged by the write.
- req0 and req1 both held high for 4 accesses, PRIO_FIXED=0 → grant order 0,1,0,1; each rvalid 2 edges after its gnt; accesses spaced 3 cycles apart.
- Same as above with PRIO_FIXED=1 → all four grants to port 0; port 1 granted only once req0 drops.
- Port 0 write 0xAAAA5555 to 0x0020, reset asserted on the edge ending ACCESS → memory[0x0020]=0xAAAA5555; no rvalid0; all outputs 0; next request served normally.
- Port 1 read, reset asserted in RESP → no rvalid1; rdata1 remains 0; busy=0 the cycle after reset.
